// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scan_pkg
//  Purpose  : Shared constants and state encoding for the 3-bit scan sequencer
//  Revision : 1.0  initial release
// ============================================================================
package scan_pkg;

   localparam int NCH   = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/next_enabled_3b.sv
`default_nettype none
// ============================================================================
//  Module   : next_enabled_3b
//  Purpose  : Finds the first enabled channel strictly after idx in the given
//             direction, wrapping around; flags the wrap and an empty mask.
//  Revision : 1.0  initial release
// ============================================================================
module next_enabled_3b
   import scan_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic [NCH-1:0]   mask,
   input  logic             dir,
   output logic [IDX_W-1:0] nxt_idx,
   output logic             wrap,
   output logic             none
);

   // One extra bit holds the carry/borrow, which is exactly the wrap flag.
   logic [IDX_W:0]   step_sum;
   logic [IDX_W-1:0] cand;
   logic             found;

   // Priority search over the 8 candidate offsets, nearest first.
   always_comb begin
      nxt_idx  = idx;
      wrap     = 1'b0;
      found    = 1'b0;
      step_sum = '0;
      cand     = '0;
      none     = (mask == '0);
      for (int k = 1; k <= NCH; k++) begin
         if (dir == DIR_UP) begin
            step_sum = {1'b0, idx} + (IDX_W+1)'(k);
         end else begin
            step_sum = {1'b0, idx} - (IDX_W+1)'(k);
         end
         cand = step_sum[IDX_W-1:0];
         if (!found && mask[cand]) begin
            found   = 1'b1;
            nxt_idx = cand;
            wrap    = step_sum[IDX_W];
         end
      end
   end

endmodule : next_enabled_3b
`default_nettype wire

// File: rtl/scan_sequencer_3b.sv
`default_nettype none
// ============================================================================
//  Module   : scan_sequencer_3b
//  Purpose  : Select-code generator for a 3-to-8 decoder. Steps through the
//             enabled channels in the latched direction, holding each for
//             dwell+1 cycles, single pass or continuous.
//  Revision : 1.0  initial release
// ============================================================================
module scan_sequencer_3b
   import scan_pkg::*;
#(
   parameter int DWELL_W = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic               dir,
   input  logic [NCH-1:0]     mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [IDX_W-1:0]   sel,
   output logic               sel_valid,
   output logic               busy,
   output logic               done
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   sel_q,   sel_d;
   logic [DWELL_W-1:0] cnt_q,   cnt_d;
   logic [NCH-1:0]     mask_q,  mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               cont_q,  cont_d;
   logic               dir_q,   dir_d;
   logic               done_q,  done_d;

   logic [IDX_W-1:0]   nxt_idx;
   logic               nxt_wrap;
   logic               nxt_none;
   logic [IDX_W-1:0]   first_seed;
   logic [IDX_W-1:0]   first_idx;
   logic               first_wrap_unused;
   logic               first_none;

   // Seeding from the far end makes the wrapping search return the first
   // channel of a pass in the requested direction.
   assign first_seed = (dir == DIR_UP) ? {IDX_W{1'b1}} : {IDX_W{1'b0}};

   next_enabled_3b u_next (
      .idx     (sel_q),
      .mask    (mask_q),
      .dir     (dir_q),
      .nxt_idx (nxt_idx),
      .wrap    (nxt_wrap),
      .none    (nxt_none)
   );

   next_enabled_3b u_first (
      .idx     (first_seed),
      .mask    (mask),
      .dir     (dir),
      .nxt_idx (first_idx),
      .wrap    (first_wrap_unused),
      .none    (first_none)
   );

   // State, counter, config and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         dwell_q <= '0;
         cont_q  <= 1'b0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         dwell_q <= dwell_d;
         cont_q  <= cont_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: start/stop handling, dwell counting and channel advance.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      dwell_d = dwell_q;
      cont_d  = cont_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop && !first_none) begin
               state_d = ST_SCAN;
               sel_d   = first_idx;
               cnt_d   = '0;
               mask_d  = mask;
               dwell_d = dwell;
               cont_d  = cont;
               dir_d   = dir;
            end
         end
         ST_SCAN: begin
            if (stop) begin
               state_d = ST_IDLE;
               sel_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == dwell_q) begin
               cnt_d = '0;
               if ((nxt_wrap && !cont_q) || nxt_none) begin
                  state_d = ST_IDLE;
                  sel_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  sel_d = nxt_idx;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign sel       = sel_q;
   assign sel_valid = (state_q == ST_SCAN);
   assign busy      = (state_q == ST_SCAN);
   assign done      = done_q;

endmodule : scan_sequencer_3b
`default_nettype wire

// File: tb/tb_scan_sequencer_3b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_sequencer_3b
//  Purpose  : Scoreboard bench for scan_sequencer_3b with a pass-list model
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_sequencer_3b;

   localparam int DW = 4;

   typedef struct packed {
      logic [2:0] sel;
      logic       v;
      logic       b;
      logic       d;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          stop;
   logic          cont;
   logic          dir;
   logic [7:0]    mask;
   logic [DW-1:0] dwell;
   logic [2:0]    sel;
   logic          sel_valid;
   logic          busy;
   logic          done;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: a pass is the list of enabled channels in direction
   // order, each repeated dwell+1 times; outputs are popped one per cycle.
   int          m_plan[$];
   bit          m_active = 1'b0;
   bit          m_cont;
   bit          m_dir;
   logic [7:0]  m_mask;
   int          m_dwell;

   scan_sequencer_3b #(.DWELL_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .cont      (cont),
      .dir       (dir),
      .mask      (mask),
      .dwell     (dwell),
      .sel       (sel),
      .sel_valid (sel_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic void build_pass();
      int ch;
      for (int i = 0; i < 8; i++) begin
         ch = m_dir ? (7 - i) : i;
         if (m_mask[ch]) begin
            for (int r = 0; r <= m_dwell; r++) m_plan.push_back(ch);
         end
      end
   endfunction

   // Apply one cycle of inputs and predict the outputs after the next edge.
   task automatic step(input logic r, input logic s, input logic p, input logic c,
                       input logic d, input logic [7:0] m, input logic [DW-1:0] dw);
      exp_t e;
      rst_n = r; start = s; stop = p; cont = c; dir = d; mask = m; dwell = dw;
      e = '0;
      if (!r) begin
         m_active = 1'b0;
         m_plan.delete();
      end else if (m_active) begin
         if (p) begin
            m_active = 1'b0;
            m_plan.delete();
         end else if (m_plan.size() == 0) begin
            if (m_cont) build_pass();
            else begin
               m_active = 1'b0;
               e.d = 1'b1;
            end
         end
      end else if (s && !p && m != 8'h00) begin
         m_mask = m; m_dwell = int'(dw); m_cont = c; m_dir = d;
         m_plan.delete();
         build_pass();
         m_active = 1'b1;
      end
      if (m_active) begin
         e.sel = 3'(m_plan.pop_front());
         e.v   = 1'b1;
         e.b   = 1'b1;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
   endtask

   // Monitor: compare DUT outputs against the scoreboard mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (sel !== e.sel || sel_valid !== e.v || busy !== e.b || done !== e.d) begin
            n_fail++;
            $display("FAIL outputs t=%0t got sel=%0d valid=%b busy=%b done=%b, expected sel=%0d valid=%b busy=%b done=%b",
                     $time, sel, sel_valid, busy, done, e.sel, e.v, e.b, e.d);
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; dir = 1'b0;
      mask = 8'h00; dwell = '0;
      #1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
      idle(2);

      // Reset held two cycles in the middle of a scan.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd3);
      idle(5);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd3);
      idle(3);

      // Single ascending pass over all channels, no dwell.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd0);
      idle(11);

      // Descending with skipped channels and dwell of 2.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'b1010_0010, 4'd2);
      idle(12);

      // Continuous wrap over channels 0 and 7, stopped mid-hold.
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'b1000_0001, 4'd1);
      idle(6);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, '0);
      idle(3);

      // Corners: empty mask, start+stop, start during scan.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1);
      idle(2);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 4'd1);
      idle(2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0011_0100, 4'd1);
      idle(2);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd0);
      idle(6);

      // Stop coinciding with the wrap terminal count of a single-channel pass.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 4'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, '0);
      idle(3);

      // Single enabled channel in continuous mode.
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 4'd2);
      idle(10);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, '0);
      idle(2);

      // Config inputs change during scan; latched values must be used.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0100_1001, 4'd1);
      for (int i = 0; i < 10; i++)
         step(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom));
      idle(3);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         logic       r, s, p, c, d;
         logic [7:0] m;
         logic [3:0] dw;
         r  = ($urandom_range(0, 299) != 0);
         s  = ($urandom_range(0, 5) == 0);
         p  = ($urandom_range(0, 39) == 0);
         c  = 1'($urandom);
         d  = 1'($urandom);
         case ($urandom_range(0, 5))
            0:       m = 8'h00;
            1:       m = 8'(1 << $urandom_range(0, 7));
            default: m = 8'($urandom);
         endcase
         dw = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
         step(r, s, p, c, d, m, dw);
      end
      idle(40);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
      idle(2);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_scan_sequencer_3b
`default_nettype wire
